mips_mem_responder: RTL and testbench

- Memory-side responder for the multicycle MIPS core's unified bus (adr, writedata, memwrite, readdata).
- Serves a word-addressed RAM and a small memory-mapped I/O (MMIO) window.
- The MMIO window holds a byte output FIFO drained by a valid/ready stream, a status register and a free-running cycle counter.
- Read data is combinational because the core samples readdata in the same cycle it drives adr.

---
 rtl/mips_mem_map_pkg.sv | 30 +++
 rtl/byte_fifo.sv | 52 +++++
 rtl/mips_mem_responder.sv | 125 ++++++++++++
 tb/tb_mips_mem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_map_pkg.sv
// rtl/mips_mem_map_pkg.sv - MMIO map constants and register decode for mips_mem_responder
package mips_mem_map_pkg;

    localparam logic [15:0] MMIO_BASE_HI = 16'hFFFF;
    localparam logic [15:0] TXDATA_OFF   = 16'h0000;
    localparam logic [15:0] STATUS_OFF   = 16'h0004;
    localparam logic [15:0] CYCLES_OFF   = 16'h0008;

    localparam int ST_EMPTY  = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_MIS    = 3;
    localparam int ST_CNT_LO = 4;

    typedef enum logic [1:0] {
        REG_TXDATA,
        REG_STATUS,
        REG_CYCLES,
        REG_NONE
    } mmio_reg_e;

    // Offsets are compared on word granularity; the byte lane never selects a register.
    function automatic mmio_reg_e decode_reg(input logic [15:2] off_word);
        if (off_word == TXDATA_OFF[15:2])      return REG_TXDATA;
        else if (off_word == STATUS_OFF[15:2]) return REG_STATUS;
        else if (off_word == CYCLES_OFF[15:2]) return REG_CYCLES;
        else                                   return REG_NONE;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous byte FIFO with occupancy count, async active-low reset
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - RAM + MMIO responder for the multicycle MIPS bus; option MIPS_RESP_ALIGN_CHECK_EN
module mips_mem_responder
    import mips_mem_map_pkg::*;
#(
    parameter int MEM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic [31:0] readdata,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int RAM_AW = $clog2(MEM_WORDS);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram [MEM_WORDS];
    logic [31:0]   cycles;
    logic [31:0]   status;
    logic          overflow;
    logic          misalign;
    logic          mmio;
    logic          aligned;
    logic          store;
    logic          push_req;
    logic          pop_req;
    logic          stat_wr;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_dout;
    mmio_reg_e     sel;

    assign mmio = (adr[31:16] == MMIO_BASE_HI);
    assign sel  = mmio ? decode_reg(adr[15:2]) : REG_NONE;

`ifdef MIPS_RESP_ALIGN_CHECK_EN
    assign aligned = (adr[1:0] == 2'b00);
`else
    logic unused_byte_lane;
    assign unused_byte_lane = ^adr[1:0];
    assign aligned          = 1'b1;
`endif

    // Stores are held off while reset is asserted so nothing is disturbed mid-reset.
    assign store    = memwrite && reset && aligned;
    assign push_req = store && (sel == REG_TXDATA);
    assign stat_wr  = store && (sel == REG_STATUS);
    assign pop_req  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (store && !mmio) begin
            ram[adr[RAM_AW+1:2]] <= writedata;
        end
    end

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (writedata[7:0]),
        .pop   (pop_req),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_dout;

    // Set conditions take priority over a clear write landing in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles   <= '0;
            overflow <= 1'b0;
        end else begin
            cycles <= cycles + 32'd1;
            if (push_req && fifo_full && !pop_req)
                overflow <= 1'b1;
            else if (stat_wr && writedata[ST_OVF])
                overflow <= 1'b0;
        end
    end

`ifdef MIPS_RESP_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            misalign <= 1'b0;
        else if (memwrite && !aligned)
            misalign <= 1'b1;
        else if (stat_wr && writedata[ST_MIS])
            misalign <= 1'b0;
    end
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        status                 = '0;
        status[ST_EMPTY]       = fifo_empty;
        status[ST_FULL]        = fifo_full;
        status[ST_OVF]         = overflow;
        status[ST_MIS]         = misalign;
        status[ST_CNT_LO +: 4] = 4'(fifo_count);
    end

    always_comb begin
        readdata = '0;
        if (!mmio) begin
            readdata = ram[adr[RAM_AW+1:2]];
        end else begin
            case (sel)
                REG_STATUS: readdata = status;
                REG_CYCLES: readdata = cycles;
                default:    readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb/tb_mips_mem_responder.sv - directed self-checking bench with byte scoreboard for mips_mem_responder
module tb_mips_mem_responder;

    localparam logic [31:0] TX  = 32'hFFFF_0000;
    localparam logic [31:0] ST  = 32'hFFFF_0004;
    localparam logic [31:0] CYC = 32'hFFFF_0008;

    logic        clk;
    logic        reset;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic        memwrite;
    logic [31:0] readdata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    int          errors;
    int          checks;
    logic [7:0]  sb [$];

    mips_mem_responder #(.MEM_WORDS(256), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .adr       (adr),
        .writedata (writedata),
        .memwrite  (memwrite),
        .readdata  (readdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        adr       = a;
        writedata = d;
        memwrite  = 1'b1;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        adr = a;
        #1;
        d = readdata;
    endtask

    task automatic tx_push(input logic [7:0] b);
        if (sb.size() < 8) sb.push_back(b);
        bus_write(TX, {24'h0, b});
    endtask

    task automatic drain_one(input string tag);
        logic [7:0] exp_b;
        out_ready = 1'b1;
        adr       = 32'h0;
        #1;
        check({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
        if (sb.size() > 0) begin
            exp_b = sb.pop_front();
            check({tag, "_data"}, {24'h0, out_data}, {24'h0, exp_b});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] c1;
        logic [31:0] c2;
        logic [31:0] ram40;
        logic [7:0]  exp_b;

        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        adr       = 32'h0;
        writedata = 32'h0;
        memwrite  = 1'b0;
        out_ready = 1'b0;
        #1;
        reset = 1'b0;

        bus_read(ST, rd);
        check("reset_status", rd, 32'h1);
        bus_read(CYC, rd);
        check("reset_cycles", rd, 32'h0);
        check("reset_valid", {31'h0, out_valid}, 32'h0);
        check("reset_data", {24'h0, out_data}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        bus_write(32'h0000_0040, 32'hDEAD_BEEF);
        bus_read(32'h0000_0040, rd);
        check("ram_rd", rd, 32'hDEAD_BEEF);
        bus_read(32'h0000_0440, rd);
        check("ram_alias", rd, 32'hDEAD_BEEF);
        bus_read(32'h0000_0043, rd);
        check("ram_misaligned_rd", rd, 32'hDEAD_BEEF);
        bus_read(32'hFFFF_0010, rd);
        check("mmio_unmapped_rd", rd, 32'h0);

        bus_write(32'h0000_0042, 32'hCAFE_F00D);
`ifdef MIPS_RESP_ALIGN_CHECK_EN
        ram40 = 32'hDEAD_BEEF;
        bus_read(32'h0000_0040, rd);
        check("mis_ram_kept", rd, ram40);
        bus_read(ST, rd);
        check("mis_status_set", rd, 32'h9);
        bus_write(ST, 32'h8);
        bus_read(ST, rd);
        check("mis_status_clr", rd, 32'h1);
`else
        ram40 = 32'hCAFE_F00D;
        bus_read(32'h0000_0040, rd);
        check("unal_ram_written", rd, ram40);
        bus_read(ST, rd);
        check("unal_status", rd, 32'h1);
        bus_write(ST, 32'h8);
        bus_read(ST, rd);
        check("unal_status_bit3_ignored", rd, 32'h1);
`endif

        // First push: no same-cycle bypass onto out_valid.
        adr       = TX;
        writedata = 32'h41;
        memwrite  = 1'b1;
        sb.push_back(8'h41);
        #1;
        check("no_bypass_valid", {31'h0, out_valid}, 32'h0);
        bus_read(ST, rd);
        check("no_bypass_status", rd, 32'h1);
        adr = TX;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        check("push1_valid", {31'h0, out_valid}, 32'h1);
        check("push1_data", {24'h0, out_data}, 32'h41);
        bus_read(ST, rd);
        check("push1_status", rd, 32'h10);

        for (int i = 2; i <= 8; i++) tx_push(8'(8'h40 + i));
        bus_read(ST, rd);
        check("fifo_full_status", rd, 32'h82);
        tx_push(8'h49);
        bus_read(ST, rd);
        check("fifo_overflow_status", rd, 32'h86);

        // Full FIFO with consumer ready: push and pop land together.
        out_ready = 1'b1;
        adr       = TX;
        writedata = 32'h50;
        memwrite  = 1'b1;
        #1;
        exp_b = sb.pop_front();
        check("fullpp_head", {24'h0, out_data}, {24'h0, exp_b});
        sb.push_back(8'h50);
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
        out_ready = 1'b0;
        bus_read(ST, rd);
        check("fullpp_status", rd, 32'h86);

        bus_write(ST, 32'h4);
        bus_read(ST, rd);
        check("ovf_clear_status", rd, 32'h82);

        for (int i = 0; i < 8; i++) drain_one("drain");
        check("drain_sb_empty", sb.size(), 32'h0);
        #1;
        check("drain_valid_low", {31'h0, out_valid}, 32'h0);
        bus_read(ST, rd);
        check("drain_status", rd, 32'h1);

        @(posedge clk);
        #1;
        bus_read(CYC, c1);
        repeat (10) @(posedge clk);
        #1;
        bus_read(CYC, c2);
        check("cycles_delta", c2 - c1, 32'd10);
        bus_read(CYC, c1);
        bus_write(CYC, 32'h0);
        bus_read(CYC, c2);
        check("cycles_write_ignored", c2 - c1, 32'd1);

        // Reset asserted mid-cycle with bytes queued.
        tx_push(8'h61);
        tx_push(8'h62);
        tx_push(8'h63);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_data", {24'h0, out_data}, 32'h0);
        bus_read(CYC, rd);
        check("midrst_cycles", rd, 32'h0);
        bus_read(ST, rd);
        check("midrst_status", rd, 32'h1);
        sb.delete();
        bus_write(TX, 32'h77);
        bus_read(ST, rd);
        check("midrst_write_blocked", rd, 32'h1);
        reset = 1'b1;
        bus_read(32'h0000_0040, rd);
        check("ram_survives_reset", rd, ram40);

        tx_push(8'h70);
        drain_one("post_reset");
        #1;
        check("post_reset_empty", {31'h0, out_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
